// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes and PC source.
// Used by the control FSM, the datapath top and the testbench.
package controle_pkg;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5
  } estado_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_LW   = 6'h02;
  localparam logic [5:0] OP_SW   = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_JMP  = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [1:0] PC_MAIS4  = 2'd0;
  localparam logic [1:0] PC_DESVIO = 2'd1;
  localparam logic [1:0] PC_SALTO  = 2'd2;

  function automatic logic opcode_valido(input logic [5:0] op);
    return (op == OP_R)   || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_JMP)  || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_contador_timeout.sv
// Memory-wait cycle counter; o_expirou is high once LIMITE-1 waiting cycles have elapsed.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module contador_timeout #(
  parameter int LIMITE = 16
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expirou
);

  localparam int W = (LIMITE > 1) ? $clog2(LIMITE) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expirou) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expirou = (r_cnt == W'(LIMITE - 1));

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback strobes for ProcessorE.
// Optional macro MEM_TIMEOUT_EN bounds memory waits and parks the FSM in PARADO on expiry.
module unidade_controle_multiciclo
  import controle_pkg::*;
#(
  parameter int OPCODE_W       = 6,
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrucao,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ext_ctrl,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [2:0]  estado,
  output logic        parado,
  output logic        erro
);

  estado_t               r_estado;
  estado_t               w_estado_prox;
  logic [OPCODE_W-1:0]   r_opcode;
  logic                  w_expirou;
  logic                  w_unused_bits;

  assign w_unused_bits = ^{instrucao[31-OPCODE_W:0], (TIMEOUT_CICLOS > 0)};

`ifdef MEM_TIMEOUT_EN
  logic w_espera;

  assign w_espera = (r_estado == BUSCA) || (r_estado == MEMORIA);

  contador_timeout #(
    .LIMITE (TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_clear   (!w_espera || mem_ready),
    .i_enable  (w_espera && !mem_ready),
    .o_expirou (w_expirou)
  );
`else
  assign w_expirou = 1'b0;
`endif

  // State register and opcode latch; the opcode is captured on the completing fetch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= BUSCA;
      r_opcode <= '0;
    end else begin
      r_estado <= w_estado_prox;
      if ((r_estado == BUSCA) && mem_ready) begin
        r_opcode <= instrucao[31 -: OPCODE_W];
      end
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    unique case (r_estado)
      BUSCA: begin
        if (mem_ready)      w_estado_prox = DECODIFICA;
        else if (w_expirou) w_estado_prox = PARADO;
      end
      DECODIFICA: begin
        if (r_opcode == OP_HALT)          w_estado_prox = PARADO;
        else if (!opcode_valido(r_opcode)) w_estado_prox = BUSCA;
        else                              w_estado_prox = EXECUTA;
      end
      EXECUTA: begin
        if ((r_opcode == OP_LW) || (r_opcode == OP_SW))      w_estado_prox = MEMORIA;
        else if ((r_opcode == OP_R) || (r_opcode == OP_ADDI)) w_estado_prox = ESCRITA;
        else                                                  w_estado_prox = BUSCA;
      end
      MEMORIA: begin
        if (mem_ready)      w_estado_prox = (r_opcode == OP_LW) ? ESCRITA : BUSCA;
        else if (w_expirou) w_estado_prox = PARADO;
      end
      ESCRITA: w_estado_prox = BUSCA;
      PARADO:  w_estado_prox = PARADO;
      default: w_estado_prox = BUSCA;
    endcase
  end

  // Strobes are forced low while reset is asserted so nothing reaches the datapath mid-reset.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_MAIS4;
    ext_ctrl    = 1'b1;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    parado      = 1'b0;
    erro        = 1'b0;
    if (reset) begin
      unique case (r_estado)
        BUSCA: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end else begin
            erro = w_expirou;
          end
        end
        DECODIFICA: begin
          ext_ctrl = (r_opcode != OP_JMP);
          erro     = !opcode_valido(r_opcode);
        end
        EXECUTA: begin
          ext_ctrl    = (r_opcode != OP_JMP);
          alu_src_imm = (r_opcode == OP_ADDI) || (r_opcode == OP_LW) || (r_opcode == OP_SW);
          if ((r_opcode == OP_BEQ) && zero) begin
            pc_write = 1'b1;
            pc_src   = PC_DESVIO;
          end else if (r_opcode == OP_JMP) begin
            pc_write = 1'b1;
            pc_src   = PC_SALTO;
          end
        end
        MEMORIA: begin
          mem_read  = (r_opcode == OP_LW);
          mem_write = (r_opcode == OP_SW);
          erro      = w_expirou && !mem_ready;
        end
        ESCRITA: begin
          reg_write  = 1'b1;
          mem_to_reg = (r_opcode == OP_LW);
        end
        PARADO:  parado = 1'b1;
        default: ;
      endcase
    end
  end

  assign estado = r_estado;

endmodule
